// File: rtl/lock_key_pkg.sv
// Shared constants, state encoding and the CRC-8 step for the c432 key loader.
package lock_key_pkg;

    localparam int         KEY_W       = 42;
    localparam int         CRC_W       = 8;
    localparam logic [7:0] CRC_POLY    = 8'h07;
    localparam int         MUX_KEY_LSB = 0;
    localparam int         XOR_KEY_LSB = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_SHIFT_KEY = 3'd1;
    localparam state_t ST_SHIFT_CRC = 3'd2;
    localparam state_t ST_CHECK     = 3'd3;
    localparam state_t ST_COMMITTED = 3'd4;
    localparam state_t ST_LOCKOUT   = 3'd5;

    // One MSB-first CRC-8 update, poly 0x07, no reflection.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                   input logic             din);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator over the incoming key bits.
module crc8_serial
    import lock_key_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/lock_key_loader.sv
// Serial key loader for the locked c432 netlist: CRC-checked shift-in, commit, lockout.
// state        | meaning
// ST_IDLE      | no key committed, waiting for load_start
// ST_SHIFT_KEY | accepting KEY_W key bits, LSB first
// ST_SHIFT_CRC | accepting CRC_W checksum bits, MSB first
// ST_CHECK     | one cycle: compare checksum, commit or count a failure
// ST_COMMITTED | key_out holds a committed key
// ST_LOCKOUT   | too many failures; key forced to zero until rst
module lock_key_loader
    import lock_key_pkg::*;
#(
    parameter int MAX_FAIL     = 3,
    parameter bit ALLOW_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err,
    output logic             locked_out,
    output logic [1:0]       fail_cnt
);

    localparam int               CNT_W        = $clog2(KEY_W);
    localparam logic [CNT_W-1:0] CNT_KEY_LOAD = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] CNT_CRC_LOAD = CNT_W'(CRC_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [1:0]       FAIL_LIMIT   = 2'(MAX_FAIL);

    state_t           state;
    logic [KEY_W-1:0] shadow;
    logic [CRC_W-1:0] rx_crc;
    logic [CRC_W-1:0] crc_val;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             start_ok;
    logic             crc_en;
    logic             crc_ok;
    logic [1:0]       fail_next;

    assign bit_ready  = (state == ST_SHIFT_KEY) || (state == ST_SHIFT_CRC);
    assign busy       = bit_ready || (state == ST_CHECK);
    assign locked_out = (state == ST_LOCKOUT);
    assign accept     = bit_ready && bit_valid;
    assign start_ok   = load_start &&
                        ((state == ST_IDLE) || (ALLOW_RELOAD && (state == ST_COMMITTED)));
    assign crc_en     = accept && (state == ST_SHIFT_KEY);
    assign crc_ok     = (crc_val == rx_crc);
    assign fail_next  = (fail_cnt == FAIL_LIMIT) ? fail_cnt : fail_cnt + 2'd1;

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_ok),
        .en     (crc_en),
        .bit_in (bit_in),
        .crc    (crc_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shadow    <= '0;
            rx_crc    <= '0;
            bit_cnt   <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
            fail_cnt  <= 2'd0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE, ST_COMMITTED: begin
                    if (start_ok) begin
                        state   <= ST_SHIFT_KEY;
                        bit_cnt <= CNT_KEY_LOAD;
                    end
                end
                ST_SHIFT_KEY: begin
                    if (accept) begin
                        // Right shift so the first bit lands in shadow[0] after KEY_W bits.
                        shadow <= {bit_in, shadow[KEY_W-1:1]};
                        if (bit_cnt == '0) begin
                            state   <= ST_SHIFT_CRC;
                            bit_cnt <= CNT_CRC_LOAD;
                        end else begin
                            bit_cnt <= bit_cnt - CNT_ONE;
                        end
                    end
                end
                ST_SHIFT_CRC: begin
                    if (accept) begin
                        rx_crc <= {rx_crc[CRC_W-2:0], bit_in};
                        if (bit_cnt == '0) begin
                            state <= ST_CHECK;
                        end else begin
                            bit_cnt <= bit_cnt - CNT_ONE;
                        end
                    end
                end
                ST_CHECK: begin
                    if (crc_ok) begin
                        key_out   <= shadow;
                        key_valid <= 1'b1;
                        fail_cnt  <= 2'd0;
                        state     <= ST_COMMITTED;
                    end else begin
                        err      <= 1'b1;
                        fail_cnt <= fail_next;
                        if (fail_next == FAIL_LIMIT) begin
                            key_out   <= '0;
                            key_valid <= 1'b0;
                            state     <= ST_LOCKOUT;
                        end else begin
                            state <= key_valid ? ST_COMMITTED : ST_IDLE;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    state <= ST_LOCKOUT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: one instance without reload, one with reload.
module tb_lock_key_loader;

    localparam logic [41:0] KEY_B = 42'h2A5_C3F0_1E96;
    localparam logic [41:0] KEY_C = 42'h1F0_0AB5_5C3D;

    logic clk = 1'b0;
    logic rst, load_start, bit_valid, bit_in, sel1;
    logic ls0, bv0, ls1, bv1;

    logic        bit_ready0, key_valid0, busy0, err0, locked0;
    logic [41:0] key_out0;
    logic [1:0]  fail_cnt0;
    logic        bit_ready1, key_valid1, busy1, err1, locked1;
    logic [41:0] key_out1;
    logic [1:0]  fail_cnt1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign ls0 = load_start & ~sel1;
    assign bv0 = bit_valid & ~sel1;
    assign ls1 = load_start & sel1;
    assign bv1 = bit_valid & sel1;

    lock_key_loader #(.MAX_FAIL(3), .ALLOW_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load_start(ls0), .bit_valid(bv0), .bit_in(bit_in),
        .bit_ready(bit_ready0), .key_out(key_out0), .key_valid(key_valid0),
        .busy(busy0), .err(err0), .locked_out(locked0), .fail_cnt(fail_cnt0)
    );

    lock_key_loader #(.MAX_FAIL(3), .ALLOW_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .load_start(ls1), .bit_valid(bv1), .bit_in(bit_in),
        .bit_ready(bit_ready1), .key_out(key_out1), .key_valid(key_valid1),
        .busy(busy1), .err(err1), .locked_out(locked1), .fail_cnt(fail_cnt1)
    );

    function automatic logic [7:0] m_step(input logic [7:0] c, input logic b);
        logic [7:0] n;
        n = {c[6:0], 1'b0};
        if (c[7] ^ b) n = n ^ 8'h07;
        return n;
    endfunction

    function automatic logic [7:0] m_crc(input logic [41:0] k);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 42; i++) c = m_step(c, k[i]);
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_key(input logic [41:0] k, input int n, input bit gaps, input bit chk);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = k[i];
            @(posedge clk);
            #1;
            c = m_step(c, k[i]);
            if (chk) begin
                tests++;
                if (dut0.u_crc.crc !== c) begin
                    failed++;
                    $display("FAIL crc_track bit %0d: got %h want %h", i, dut0.u_crc.crc, c);
                end
            end
            if (gaps) begin
                @(negedge clk);
                bit_valid = 1'b0;
                @(posedge clk);
            end
        end
    endtask

    task automatic send_crc(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            bit_valid = 1'b1;
            bit_in    = c[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_check();
        @(negedge clk);
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sel1 = 1'b0;
        do_reset();
        tests++; if (key_out0 !== 42'h0) begin failed++; $display("FAIL reset key_out: got %h want 0", key_out0); end
        tests++; if (key_valid0 !== 1'b0) begin failed++; $display("FAIL reset key_valid: got %b want 0", key_valid0); end
        tests++; if (busy0 !== 1'b0) begin failed++; $display("FAIL reset busy: got %b want 0", busy0); end
        tests++; if (err0 !== 1'b0) begin failed++; $display("FAIL reset err: got %b want 0", err0); end
        tests++; if (locked0 !== 1'b0) begin failed++; $display("FAIL reset locked_out: got %b want 0", locked0); end
        tests++; if (fail_cnt0 !== 2'd0) begin failed++; $display("FAIL reset fail_cnt: got %0d want 0", fail_cnt0); end
        tests++; if (bit_ready0 !== 1'b0) begin failed++; $display("FAIL reset bit_ready: got %b want 0", bit_ready0); end
        tests++; if (key_out1 !== 42'h0) begin failed++; $display("FAIL reset key_out1: got %h want 0", key_out1); end
        tests++; if (key_valid1 !== 1'b0) begin failed++; $display("FAIL reset key_valid1: got %b want 0", key_valid1); end
    endtask

    task automatic test_zero_key();
        sel1 = 1'b0;
        start_load();
        tests++; if (bit_ready0 !== 1'b1) begin failed++; $display("FAIL zero bit_ready: got %b want 1", bit_ready0); end
        tests++; if (busy0 !== 1'b1) begin failed++; $display("FAIL zero busy_start: got %b want 1", busy0); end
        send_key(42'h0, 42, 1'b0, 1'b0);
        send_crc(8'h00);
        tests++; if (busy0 !== 1'b1) begin failed++; $display("FAIL zero busy_check: got %b want 1", busy0); end
        tests++; if (bit_ready0 !== 1'b0) begin failed++; $display("FAIL zero bit_ready_check: got %b want 0", bit_ready0); end
        tests++; if (key_valid0 !== 1'b0) begin failed++; $display("FAIL zero early_valid: got %b want 0", key_valid0); end
        step_check();
        tests++; if (key_valid0 !== 1'b1) begin failed++; $display("FAIL zero key_valid: got %b want 1", key_valid0); end
        tests++; if (key_out0 !== 42'h0) begin failed++; $display("FAIL zero key_out: got %h want 0", key_out0); end
        tests++; if (busy0 !== 1'b0) begin failed++; $display("FAIL zero busy_end: got %b want 0", busy0); end
        tests++; if (err0 !== 1'b0) begin failed++; $display("FAIL zero err: got %b want 0", err0); end
    endtask

    task automatic test_bit0_gaps();
        sel1 = 1'b0;
        do_reset();
        start_load();
        send_key(42'h1, 42, 1'b1, 1'b1);
        send_crc(m_crc(42'h1));
        step_check();
        tests++; if (key_out0 !== 42'h1) begin failed++; $display("FAIL bit0 key_out: got %h want 1", key_out0); end
        tests++; if (key_out0[0] !== 1'b1) begin failed++; $display("FAIL bit0 p1: got %b want 1", key_out0[0]); end
        tests++; if (key_out0[41:4] !== 38'h0) begin failed++; $display("FAIL bit0 xor_bits: got %h want 0", key_out0[41:4]); end
        tests++; if (key_valid0 !== 1'b1) begin failed++; $display("FAIL bit0 key_valid: got %b want 1", key_valid0); end
    endtask

    task automatic test_no_reload();
        sel1 = 1'b0;
        start_load();
        tests++; if (busy0 !== 1'b0) begin failed++; $display("FAIL noreload busy: got %b want 0", busy0); end
        tests++; if (bit_ready0 !== 1'b0) begin failed++; $display("FAIL noreload bit_ready: got %b want 0", bit_ready0); end
        send_key(KEY_B, 42, 1'b0, 1'b0);
        send_crc(m_crc(KEY_B));
        step_check();
        tests++; if (key_out0 !== 42'h1) begin failed++; $display("FAIL noreload key_out: got %h want 1", key_out0); end
        tests++; if (key_valid0 !== 1'b1) begin failed++; $display("FAIL noreload key_valid: got %b want 1", key_valid0); end
        tests++; if (busy0 !== 1'b0) begin failed++; $display("FAIL noreload busy_end: got %b want 0", busy0); end
    endtask

    task automatic test_bad_crc();
        sel1 = 1'b1;
        do_reset();
        start_load();
        send_key(42'h1, 42, 1'b0, 1'b0);
        send_crc(m_crc(42'h1));
        step_check();
        tests++; if (key_out1 !== 42'h1) begin failed++; $display("FAIL badcrc first_commit: got %h want 1", key_out1); end
        start_load();
        send_key(42'h1, 42, 1'b0, 1'b0);
        send_crc(m_crc(42'h1) ^ 8'h10);
        step_check();
        tests++; if (err1 !== 1'b1) begin failed++; $display("FAIL badcrc err: got %b want 1", err1); end
        tests++; if (fail_cnt1 !== 2'd1) begin failed++; $display("FAIL badcrc fail_cnt: got %0d want 1", fail_cnt1); end
        tests++; if (key_out1 !== 42'h1) begin failed++; $display("FAIL badcrc key_out: got %h want 1", key_out1); end
        tests++; if (key_valid1 !== 1'b1) begin failed++; $display("FAIL badcrc key_valid: got %b want 1", key_valid1); end
        tests++; if (busy1 !== 1'b0) begin failed++; $display("FAIL badcrc busy: got %b want 0", busy1); end
        @(posedge clk);
        #1;
        tests++; if (err1 !== 1'b0) begin failed++; $display("FAIL badcrc err_pulse: got %b want 0", err1); end
    endtask

    task automatic test_reload();
        sel1 = 1'b1;
        start_load();
        tests++; if (busy1 !== 1'b1) begin failed++; $display("FAIL reload accepted: got %b want 1", busy1); end
        send_key(KEY_B, 42, 1'b0, 1'b0);
        tests++; if (key_out1 !== 42'h1) begin failed++; $display("FAIL reload hold_key: got %h want 1", key_out1); end
        tests++; if (key_valid1 !== 1'b1) begin failed++; $display("FAIL reload hold_valid: got %b want 1", key_valid1); end
        send_crc(m_crc(KEY_B));
        tests++; if (key_out1 !== 42'h1) begin failed++; $display("FAIL reload at_check: got %h want 1", key_out1); end
        step_check();
        tests++; if (key_out1 !== KEY_B) begin failed++; $display("FAIL reload new_key: got %h want %h", key_out1, KEY_B); end
        tests++; if (fail_cnt1 !== 2'd0) begin failed++; $display("FAIL reload fail_cnt: got %0d want 0", fail_cnt1); end
    endtask

    task automatic test_rst_mid_load();
        sel1 = 1'b1;
        start_load();
        send_key(KEY_C, 20, 1'b0, 1'b0);
        @(negedge clk);
        bit_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (key_out1 !== 42'h0) begin failed++; $display("FAIL midrst key_out: got %h want 0", key_out1); end
        tests++; if (key_valid1 !== 1'b0) begin failed++; $display("FAIL midrst key_valid: got %b want 0", key_valid1); end
        tests++; if (busy1 !== 1'b0) begin failed++; $display("FAIL midrst busy: got %b want 0", busy1); end
        tests++; if (bit_ready1 !== 1'b0) begin failed++; $display("FAIL midrst bit_ready: got %b want 0", bit_ready1); end
        @(negedge clk);
        rst = 1'b0;
        start_load();
        send_key(KEY_C, 42, 1'b0, 1'b0);
        send_crc(m_crc(KEY_C));
        step_check();
        tests++; if (key_out1 !== KEY_C) begin failed++; $display("FAIL midrst reload_key: got %h want %h", key_out1, KEY_C); end
        tests++; if (key_valid1 !== 1'b1) begin failed++; $display("FAIL midrst reload_valid: got %b want 1", key_valid1); end
    endtask

    task automatic test_lockout();
        sel1 = 1'b1;
        for (int f = 1; f <= 3; f++) begin
            start_load();
            send_key(KEY_B, 42, 1'b0, 1'b0);
            send_crc(m_crc(KEY_B) ^ 8'h01);
            step_check();
            tests++; if (fail_cnt1 !== 2'(f)) begin failed++; $display("FAIL lockout fail_cnt%0d: got %0d want %0d", f, fail_cnt1, f); end
            tests++; if (locked1 !== (f == 3)) begin failed++; $display("FAIL lockout locked%0d: got %b want %b", f, locked1, f == 3); end
            tests++; if (key_out1 !== ((f == 3) ? 42'h0 : KEY_C)) begin failed++; $display("FAIL lockout key%0d: got %h", f, key_out1); end
        end
        tests++; if (key_valid1 !== 1'b0) begin failed++; $display("FAIL lockout key_valid: got %b want 0", key_valid1); end
        start_load();
        tests++; if (busy1 !== 1'b0) begin failed++; $display("FAIL lockout ignore_start: got %b want 0", busy1); end
        send_key(KEY_B, 42, 1'b0, 1'b0);
        send_crc(m_crc(KEY_B));
        step_check();
        tests++; if (locked1 !== 1'b1) begin failed++; $display("FAIL lockout still_locked: got %b want 1", locked1); end
        tests++; if (key_out1 !== 42'h0) begin failed++; $display("FAIL lockout still_zero: got %h want 0", key_out1); end
        do_reset();
        tests++; if (locked1 !== 1'b0) begin failed++; $display("FAIL lockout rst_clear: got %b want 0", locked1); end
        start_load();
        send_key(KEY_B, 42, 1'b0, 1'b0);
        send_crc(m_crc(KEY_B));
        step_check();
        tests++; if (key_out1 !== KEY_B) begin failed++; $display("FAIL lockout recommit: got %h want %h", key_out1, KEY_B); end
        tests++; if (fail_cnt1 !== 2'd0) begin failed++; $display("FAIL lockout fail_clear: got %0d want 0", fail_cnt1); end
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sel1 = 1'b0;
        test_reset();
        test_zero_key();
        test_bit0_gaps();
        test_no_reload();
        test_bad_crc();
        test_reload();
        test_rst_mid_load();
        test_lockout();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule
